z1010_ff_slice: RTL
===================

// Module: z1010_ff_slice
// PURPOSE
// - Configurable fabric register slice of the z1010 logic tile.
// - Implements the flop primitives that synthesis maps onto the fabric: dff, dffe, dffr, dffs, dffh,
//   dffl, dffeh, dffel and dffer.
// - Each of N flops takes its mode from a serially loaded configuration chain, activated by a commit strobe.
// - Sits directly downstream of flop techmapping: every mapped flop instance lands in one slot of this block.
// PARAMETERS
// - N   4  number of flop slots in the slice
// - MW  4  mode field width per slot (fixed; encodings below)
// PORTS
// - clk         in   1    fabric clock, rising edge; all flops and config logic
// - nreset      in   1    asynchronous, active-low reset
// - cfg_en      in   1    config shift enable
// - cfg_in      in   1    config serial input
// - cfg_out     out  1    config serial output; MSB of shadow chain, for daisy-chaining
// - cfg_commit  in   1    one-cycle strobe: copy shadow chain to active config
// - cfg_err     out  1    sticky: a reserved mode is committed in any slot
// - d           in   N    per-slot data
// - e           in   N    per-slot clock enable, active-high
// - r           in   N    per-slot control pin, active-low; R/S/H/L role chosen by mode
// - q           out  N    per-slot registered output
// BEHAVIOUR
// - Config chain
//   - Chain length L = N*CW. CW = MW, or MW+1 with FF_SLICE_INIT_EN.
//   - Slot i field: active[i*CW +: CW]; mode in low MW bits.
//   - cfg_en=1: shadow <= {shadow[L-2:0], cfg_in} each cycle; cfg_out = shadow[L-1].
//   - cfg_commit=1 with cfg_en=0: active <= shadow. On the next edge all q load their init value.
//   - cfg_commit=1 with cfg_en=1: shift wins; commit is dropped, active is unchanged.
//   - While cfg_en=1 every slot holds q; async modes still respond to r.
// - Mode encodings. Sync controls override e; e is ignored unless the mode lists it.
//   - 0 OFF: q held at 0
//   - 1 DFF: q <= d
//   - 2 DFFE: if e, q <= d
//   - 3 DFFR: r=0 forces q=0 asynchronously; else q <= d
//   - 4 DFFS: r=0 forces q=1 asynchronously; else q <= d
//   - 5 DFFH: r=0 gives q <= 1 at the edge; else q <= d
//   - 6 DFFL: r=0 gives q <= 0 at the edge; else q <= d
//   - 7 DFFEH: r=0 gives q <= 1 at the edge; else if e, q <= d
//   - 8 DFFEL: r=0 gives q <= 0 at the edge; else if e, q <= d
//   - 9 DFFER: r=0 forces q=0 asynchronously; else if e, q <= d
//   - 10-15 reserved: behave as OFF; set cfg_err
// - Async modes (3, 4, 9)
//   - Force applies with zero cycle delay and holds while r=0.
//   - Release is synchronous: first capture at the first rising edge after r returns to 1.
// - Latency: one clk from d/e/sync-r to q; combinational from async r to q.
// - Reset (nreset=0): shadow=0, active=0 (all OFF), q=0, cfg_err=0, cfg_out=0.
//   - Reset mid-shift discards the partial load.
//   - Reset dominates async r forces.
// - cfg_err
//   - Set on the edge that commits any reserved mode.
//   - Cleared only by nreset or by a commit with no reserved modes.
// CONFIGURATION
// - FF_SLICE_INIT_EN defined: each slot's field gains bit MW, its init value (chain length N*(MW+1)).
//   - On commit, q loads the init value.
//   - In async modes, if r=0 is asserted during commit, the r force still wins.
// - FF_SLICE_INIT_EN undefined: chain length N*MW; init value is 0 for every slot.
// - nreset always forces q=0 in both builds.
// TESTING
// - Reset then load N=4 slots all DFF (mode 1), commit; d=4'b1010 -> q=4'b1010 one edge later.
// - Slot0 DFFE: e=0, d=1 -> q stays 0; then e=1 -> q=1 at the next edge.
// - Slot1 DFFR with q=1: drop r mid-cycle -> q=0 before the next edge; raise r with d=1 -> q=1 at the first edge after.
// - Slot2 DFFEH: r=0, e=0, d=0 -> q=1 at the edge (sync set beats enable).
// - Slot3 DFFS: r=0 -> q=1 immediately.
// - Config: commit mode 12 into slot3 -> cfg_err=1, q[3]=0.
// - Config: shift 16 ones with cfg_en=1 -> cfg_out=1 on the 17th cycle.
// - Config: cfg_commit held high together with cfg_en -> active unchanged.
// - Config: nreset pulse mid-shift -> all q=0, cfg_err=0; re-commit leaves all slots OFF.
// - INIT build: commit slot0 DFF with init=1 -> q[0]=1 after commit.
// - INIT build: nreset -> q[0]=0.

Source files
------------

// File: rtl/z1010_ff_slice.sv
// z1010_ff_slice: config-chain driven fabric flop slice (dff..dffer); FF_SLICE_INIT_EN adds a per-slot init bit
module z1010_ff_slice #(
   parameter int N  = 4,
   parameter int MW = 4
) (
   input  logic         clk,
   input  logic         nreset,
   input  logic         cfg_en,
   input  logic         cfg_in,
   output logic         cfg_out,
   input  logic         cfg_commit,
   output logic         cfg_err,
   input  logic [N-1:0] d,
   input  logic [N-1:0] e,
   input  logic [N-1:0] r,
   output logic [N-1:0] q
);
`ifdef FF_SLICE_INIT_EN
   localparam int CW = MW + 1;
`else
   localparam int CW = MW;
`endif
   localparam int L = N * CW;
   localparam logic [MW-1:0] M_OFF   = MW'(0);
   localparam logic [MW-1:0] M_DFFE  = MW'(2);
   localparam logic [MW-1:0] M_DFFR  = MW'(3);
   localparam logic [MW-1:0] M_DFFS  = MW'(4);
   localparam logic [MW-1:0] M_DFFH  = MW'(5);
   localparam logic [MW-1:0] M_DFFL  = MW'(6);
   localparam logic [MW-1:0] M_DFFEH = MW'(7);
   localparam logic [MW-1:0] M_DFFEL = MW'(8);
   localparam logic [MW-1:0] M_DFFER = MW'(9);
   logic [L-1:0] shadow, active;
   logic [N-1:0] q_reg, q_nxt, init, rsv_sh;
   logic pend, commit;
   assign commit  = cfg_commit && !cfg_en;
   assign cfg_out = shadow[L-1];
   for (genvar i = 0; i < N; i++) begin : g_slot
      logic [MW-1:0] m;
      logic a_lo, a_hi, s_hi, s_lo, en_m, off;
      assign m = active[i*CW +: MW];
`ifdef FF_SLICE_INIT_EN
      assign init[i] = active[i*CW+MW];
`else
      assign init[i] = 1'b0;
`endif
      assign rsv_sh[i] = shadow[i*CW +: MW] > M_DFFER;
      assign a_lo = (m == M_DFFR || m == M_DFFER) && !r[i];
      assign a_hi = m == M_DFFS && !r[i];
      assign s_hi = (m == M_DFFH || m == M_DFFEH) && !r[i];
      assign s_lo = (m == M_DFFL || m == M_DFFEL) && !r[i];
      assign en_m = m == M_DFFE || m == M_DFFEH || m == M_DFFEL || m == M_DFFER;
      assign off  = m == M_OFF || m > M_DFFER;
      // async forces bypass the register so they reach q with no clock
      assign q[i] = a_lo ? 1'b0 : a_hi ? 1'b1 : q_reg[i];
      assign q_nxt[i] = cfg_en ? q_reg[i] : a_lo ? 1'b0 : a_hi ? 1'b1 : pend ? init[i] :
                        s_hi ? 1'b1 : s_lo ? 1'b0 : off ? 1'b0 : (en_m && !e[i]) ? q_reg[i] : d[i];
   end
   always_ff @(posedge clk or negedge nreset)
      if (!nreset) begin
         shadow  <= '0;
         active  <= '0;
         q_reg   <= '0;
         pend    <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         if (cfg_en) shadow <= {shadow[L-2:0], cfg_in};
         if (commit) begin
            active  <= shadow;
            cfg_err <= |rsv_sh;
         end
         pend  <= commit;
         q_reg <= q_nxt;
      end
endmodule
